// File: rtl/c1541_sd_arb_if.sv
// c1541_sd_arb_if: drive-side and host-side signals of the SD channel arbiter
interface c1541_sd_arb_if #(
  parameter int NDRIVES = 4
);
  logic [32*NDRIVES-1:0] drv_lba;
  logic [NDRIVES-1:0]    drv_rd;
  logic [NDRIVES-1:0]    drv_wr;
  logic [NDRIVES-1:0]    drv_ack;
  logic [NDRIVES-1:0]    drv_buff_wr;
  logic [8*NDRIVES-1:0]  drv_buff_din;
  logic [NDRIVES-1:0]    drv_err;
  logic [31:0]           sd_lba;
  logic                  sd_rd;
  logic                  sd_wr;
  logic                  sd_ack;
  logic                  sd_buff_wr;
  logic [7:0]            sd_buff_din;
  logic [1:0]            grant;
  logic                  busy;
  modport master (
    output drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
    input  drv_ack, drv_buff_wr, drv_err, sd_lba, sd_rd, sd_wr, sd_buff_din, grant, busy
  );
  modport slave (
    input  drv_lba, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
    output drv_ack, drv_buff_wr, drv_err, sd_lba, sd_rd, sd_wr, sd_buff_din, grant, busy
  );
endinterface

// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb: round-robin sharing of one SD block channel between drives
module c1541_sd_arb #(
  parameter int          NDRIVES = 4,
  parameter logic [23:0] TIMEOUT = 24'd16000000
) (
  input logic           clk_sys,
  input logic           reset_n,
  c1541_sd_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;
  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d, pick;
  logic [31:0]        lba_q, lba_d;
  logic               rd_q, rd_d, wr_q, wr_d, ack_q, found, route;
  logic [23:0]        timer_q, timer_d;
  logic [NDRIVES-1:0] err_q, err_d, pend, sel;
  assign pend  = bus.drv_rd | bus.drv_wr;
  assign route = (state_q == ISSUE) || (state_q == XFER);
  assign sel   = NDRIVES'(1) << grant_q;
  // first pending drive after the last grant; lowest distance wins
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    for (int k = NDRIVES; k >= 1; k--) begin
      if (pend[(int'(grant_q) + k) % NDRIVES]) begin
        found = 1'b1;
        pick  = 2'((int'(grant_q) + k) % NDRIVES);
      end
    end
  end
  // next-state logic; ack takes priority over abort and timeout in ISSUE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    timer_d = timer_q;
    err_d   = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        grant_d = pick;
        lba_d   = bus.drv_lba[32*int'(pick) +: 32];
        rd_d    = bus.drv_rd[pick];
        wr_d    = !bus.drv_rd[pick];
        timer_d = '0;
      end
      ISSUE: begin
        timer_d = timer_q + 24'd1;
        if (bus.sd_ack) begin
          state_d = XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (!pend[grant_q]) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (timer_q == TIMEOUT - 24'd1) begin
          state_d        = IDLE;
          rd_d           = 1'b0;
          wr_d           = 1'b0;
          err_d[grant_q] = 1'b1;
        end
      end
      XFER: state_d = (ack_q && !bus.sd_ack) ? GAP : XFER;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset also drops a request already on the host
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 2'(NDRIVES - 1);
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      timer_q <= '0;
      err_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      ack_q   <= bus.sd_ack;
    end
  end
  assign bus.drv_ack     = route ? (sel & {NDRIVES{bus.sd_ack}}) : '0;
  assign bus.drv_buff_wr = route ? (sel & {NDRIVES{bus.sd_buff_wr}}) : '0;
  assign bus.sd_buff_din = bus.drv_buff_din[8*int'(grant_q) +: 8];
  assign bus.drv_err     = err_q;
  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = rd_q;
  assign bus.sd_wr       = wr_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_c1541_sd_arb.sv
// tb_c1541_sd_arb: directed and randomized transfers checked against a transaction-level model
module tb_c1541_sd_arb;
  logic clk_sys, reset_n;
  int checks, errors, last;
  logic [31:0] lba[4];
  logic [7:0]  din[4];
  logic [3:0]  req_rd, req_wr;
  c1541_sd_arb_if #(.NDRIVES(4)) bus();
  c1541_sd_arb #(.NDRIVES(4), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic apply();
    bus.drv_rd = req_rd;
    bus.drv_wr = req_wr;
    for (int i = 0; i < 4; i++) begin
      bus.drv_lba[32*i +: 32]     = lba[i];
      bus.drv_buff_din[8*i +: 8]  = din[i];
    end
  endtask
  // round-robin rule: first requester after the last one served, wrapping
  function automatic int predict();
    for (int k = 1; k <= 4; k++)
      if (req_rd[(last + k) % 4] || req_wr[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_rd"}, bus.sd_rd, 0);
    chk({tag, "_wr"}, bus.sd_wr, 0);
    chk({tag, "_lba"}, bus.sd_lba, 0);
    chk({tag, "_grant"}, bus.grant, 3);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ack"}, bus.drv_ack, 0);
    chk({tag, "_bwr"}, bus.drv_buff_wr, 0);
    chk({tag, "_err"}, bus.drv_err, 0);
  endtask
  // one complete host transfer for whichever drive the model expects next
  task automatic do_xfer(input logic [3:0] add, input int np, input int dly, output int og);
    int g, lat;
    logic [31:0] exp_lba;
    logic exp_rd;
    bit seen;
    g = predict();
    seen = 0;
    lat = 0;
    og = -1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      lat++;
      seen = bus.sd_rd | bus.sd_wr;
    end
    chk("req_seen", seen, 1);
    if (!seen) return;
    og = int'(bus.grant);
    exp_rd  = req_rd[g];
    exp_lba = lba[g];
    chk("req_latency", lat, 1);
    chk("grant", bus.grant, g);
    chk("sd_lba", bus.sd_lba, exp_lba);
    chk("sd_op", {bus.sd_rd, bus.sd_wr}, exp_rd ? 2'b10 : 2'b01);
    lba[g] = $urandom;
    apply();
    repeat (dly) cyc();
    chk("issue_hold", {bus.sd_rd, bus.sd_wr}, exp_rd ? 2'b10 : 2'b01);
    bus.sd_ack = 1'b1;
    #1;
    chk("drv_ack", bus.drv_ack, 4'b0001 << g);
    cyc();
    chk("op_drop", {bus.sd_rd, bus.sd_wr}, 0);
    chk("lba_latched", bus.sd_lba, exp_lba);
    req_rd = req_rd | (add & ~(4'b0001 << g));
    apply();
    for (int p = 0; p < np; p++) begin
      if (exp_rd) begin
        bus.sd_buff_wr = 1'b1;
        #1;
        chk("buff_wr_on", bus.drv_buff_wr, 4'b0001 << g);
        cyc();
        bus.sd_buff_wr = 1'b0;
        #1;
        chk("buff_wr_off", bus.drv_buff_wr, 0);
      end else begin
        chk("buff_din", bus.sd_buff_din, din[g]);
        chk("buff_wr_idle", bus.drv_buff_wr, 0);
        chk("wr_low", bus.sd_wr, 0);
      end
      cyc();
    end
    bus.sd_ack = 1'b0;
    #1;
    chk("ack_fall", bus.drv_ack, 0);
    cyc();
    chk("gap_busy", bus.busy, 1);
    chk("gap_quiet", {bus.sd_rd, bus.sd_wr, bus.drv_ack}, 0);
    cyc();
    chk("idle_busy", bus.busy, 0);
    chk("idle_quiet", {bus.sd_rd, bus.sd_wr}, 0);
    req_rd[g] = 1'b0;
    req_wr[g] = 1'b0;
    apply();
    last = g;
  endtask
  initial begin
    int og, cnt, errs, guard;
    int order[4];
    checks = 0;
    errors = 0;
    last = 3;
    req_rd = '0;
    req_wr = '0;
    for (int i = 0; i < 4; i++) begin
      lba[i] = '0;
      din[i] = '0;
    end
    apply();
    bus.sd_ack = 1'b0;
    bus.sd_buff_wr = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    chk_reset("rst");
    reset_n = 1'b1;
    cyc();
    // single read from drive 0 with a full 512-byte buffer fill
    lba[0] = 32'h00000123;
    req_rd[0] = 1'b1;
    apply();
    do_xfer(4'b0000, 512, 5, og);
    chk("rd0_grant", og, 0);
    // strobes outside a transfer reach no drive
    bus.sd_buff_wr = 1'b1;
    bus.sd_ack = 1'b1;
    #1;
    chk("idle_bwr", bus.drv_buff_wr, 0);
    chk("idle_ack", bus.drv_ack, 0);
    bus.sd_buff_wr = 1'b0;
    bus.sd_ack = 1'b0;
    // write from drive 2: its buffer byte goes to the host
    din[2] = 8'hA5;
    lba[2] = 32'h0000BEEF;
    req_wr[2] = 1'b1;
    apply();
    do_xfer(4'b0000, 6, 3, og);
    chk("wr2_grant", og, 2);
    // read and write together on drive 1: read wins
    req_rd[1] = 1'b1;
    req_wr[1] = 1'b1;
    lba[1] = 32'h00010001;
    apply();
    do_xfer(4'b0000, 3, 2, og);
    chk("rw1_grant", og, 1);
    // reset in the middle of a transfer
    req_rd[2] = 1'b1;
    apply();
    cyc();
    chk("mid_rd", bus.sd_rd, 1);
    bus.sd_ack = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    req_rd = '0;
    apply();
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("stale_ack_busy", bus.busy, 0);
    chk("stale_ack_drv", bus.drv_ack, 0);
    bus.sd_ack = 1'b0;
    last = 3;
    cyc();
    // round robin among 0, 1, 3; drive 0 comes back during drive 3's transfer
    for (int i = 0; i < 4; i++) lba[i] = 32'h100 + i;
    req_rd = 4'b1011;
    apply();
    do_xfer(4'b0000, 2, 1, order[0]);
    do_xfer(4'b0000, 2, 1, order[1]);
    do_xfer(4'b0001, 2, 1, order[2]);
    do_xfer(4'b0000, 2, 1, order[3]);
    chk("rr_0", order[0], 0);
    chk("rr_1", order[1], 1);
    chk("rr_2", order[2], 3);
    chk("rr_3", order[3], 0);
    // timeout: host never acks drive 1
    req_rd = 4'b0010;
    apply();
    cyc();
    cnt = 0;
    errs = 0;
    for (int i = 0; i < 200 && bus.sd_rd; i++) begin
      cnt++;
      errs += (bus.drv_err != 0) ? 1 : 0;
      cyc();
    end
    chk("to_len", cnt, 100);
    chk("to_err_early", errs, 0);
    chk("to_err", bus.drv_err, 4'b0010);
    cyc();
    chk("to_err_clr", bus.drv_err, 0);
    chk("to_rearb", bus.sd_rd, 1);
    chk("to_grant", bus.grant, 1);
    // abort drive 1 while re-issued
    req_rd = '0;
    apply();
    #1;
    chk("ab1_ack", bus.drv_ack, 0);
    cyc();
    chk("ab1_rd", bus.sd_rd, 0);
    chk("ab1_busy", bus.busy, 0);
    last = 1;
    // abort drive 0 a few cycles into ISSUE
    req_rd = 4'b0001;
    apply();
    cyc();
    chk("ab0_rd", bus.sd_rd, 1);
    chk("ab0_grant", bus.grant, 0);
    cyc();
    cyc();
    req_rd = '0;
    apply();
    #1;
    chk("ab0_ack", bus.drv_ack, 0);
    cyc();
    chk("ab0_drop", bus.sd_rd, 0);
    chk("ab0_busy", bus.busy, 0);
    last = 0;
    // randomized request mixes
    for (int r = 0; r < 25; r++) begin
      logic [3:0] set;
      set = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        if (set[i]) begin
          int t;
          t = $urandom_range(0, 2);
          req_rd[i] = (t != 1);
          req_wr[i] = (t != 0);
          lba[i] = $urandom;
          din[i] = 8'($urandom);
        end
      end
      apply();
      guard = 0;
      while ((req_rd | req_wr) != 0 && guard < 16) begin
        logic [3:0] add;
        add = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        do_xfer(add, $urandom_range(1, 6), $urandom_range(1, 8), og);
        guard++;
        if (og < 0) break;
      end
      req_rd = '0;
      req_wr = '0;
      apply();
      cyc();
      chk("rnd_idle", bus.busy, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
